// File: rtl/kt_cmd_sequencer_pkg.sv
// Shared types and constants for the Knight command sequencer.
package kt_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT_EVT,
      S_SEND,
      S_WAIT_SENT,
      S_WAIT_RESP,
      S_DONE,
      S_ERR
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_TMO_EVT  = 2'd1,
      ERR_TMO_RESP = 2'd2,
      ERR_NAK      = 2'd3
   } err_code_t;

   localparam logic [7:0] POS_ACK = 8'hA5;
   localparam int         CMD_W   = 16;

endpackage

// File: rtl/kt_cmd_sequencer_fifo.sv
// Synchronous FIFO with wrap-bit pointers; flush empties it in one cycle.
module seq_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rd_data,
   input  logic                   flush,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign count   = wr_ptr_q - rd_ptr_q;
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset; pointers alone define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/kt_cmd_sequencer.sv
// Queued command sequencer: per entry, optionally wait on an event, send the
// command, wait for transmit completion, then check the response against ACK.
module kt_cmd_sequencer
   import kt_seq_pkg::*;
#(
   parameter int         DEPTH = 8,
   parameter int         TMO_W = 24,
   parameter int         N_EVT = 4,
   parameter logic [7:0] ACK   = POS_ACK
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [15:0]                  wr_cmd,
   input  logic [$clog2(N_EVT+1)-1:0]   wr_evt,
   input  logic [TMO_W-1:0]             wr_tmo,
   input  logic                         start,
   input  logic                         abort,
   input  logic [N_EVT-1:0]             evt,
   output logic [15:0]                  cmd,
   output logic                         send_cmd,
   input  logic                         cmd_sent,
   input  logic                         resp_rdy,
   input  logic [7:0]                   resp,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic [1:0]                   err_code,
   output logic [$clog2(DEPTH)-1:0]     err_idx,
   output logic [7:0]                   err_resp,
   output logic [$clog2(DEPTH):0]       count,
   output logic                         overflow
);

   localparam int EVT_W = $clog2(N_EVT + 1);
   localparam int IW    = $clog2(DEPTH);
   localparam int ENT_W = CMD_W + EVT_W + TMO_W;

   state_t           state_q, state_d;
   logic [CMD_W-1:0] cmd_q, cmd_d;
   logic [EVT_W-1:0] evt_sel_q, evt_sel_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [TMO_W-1:0] timer_q, timer_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             err_q, err_d;
   err_code_t        err_code_q, err_code_d;
   logic [IW-1:0]    err_idx_q, err_idx_d;
   logic [7:0]       err_resp_q, err_resp_d;
   logic             overflow_q, overflow_d;

   logic [ENT_W-1:0] head;
   logic [CMD_W-1:0] head_cmd;
   logic [EVT_W-1:0] head_evt;
   logic [TMO_W-1:0] head_tmo;
   logic             fifo_full, fifo_empty, fifo_pop;
   logic             timer_expired;

   function automatic logic evt_hit(input logic [EVT_W-1:0] sel,
                                    input logic [N_EVT-1:0] ev);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < N_EVT; k++) begin
         if (sel == EVT_W'(k + 1)) hit = ev[k];
      end
      return hit;
   endfunction

   seq_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (wr_en && !abort),
      .wr_data ({wr_cmd, wr_evt, wr_tmo}),
      .pop     (fifo_pop),
      .rd_data (head),
      .flush   (abort),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (count)
   );

   assign {head_cmd, head_evt, head_tmo} = head;

   // A zero timeout disables expiry entirely.
   assign timer_expired = (tmo_q != '0) && (timer_q == '0);

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      evt_sel_d  = evt_sel_q;
      tmo_d      = tmo_q;
      idx_d      = idx_q;
      timer_d    = timer_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      err_idx_d  = err_idx_q;
      err_resp_d = err_resp_q;
      fifo_pop   = 1'b0;
      send_cmd   = 1'b0;
      done       = 1'b0;
      overflow_d = overflow_q | (wr_en && fifo_full && !abort);

      if ((state_q == S_WAIT_EVT || state_q == S_WAIT_RESP) && timer_q != '0)
         timer_d = timer_q - TMO_W'(1);

      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d    = S_LOAD;
                  err_d      = 1'b0;
                  err_code_d = ERR_NONE;
                  err_idx_d  = '0;
                  err_resp_d = '0;
                  idx_d      = '0;
               end
            end
            S_LOAD: begin
               if (fifo_empty) begin
                  state_d = S_DONE;
               end else begin
                  cmd_d     = head_cmd;
                  evt_sel_d = head_evt;
                  tmo_d     = head_tmo;
                  timer_d   = head_tmo;
                  state_d   = (head_evt == '0) ? S_SEND : S_WAIT_EVT;
               end
            end
            S_WAIT_EVT: begin
               if (evt_hit(evt_sel_q, evt)) begin
                  state_d = S_SEND;
               end else if (timer_expired) begin
                  state_d    = S_ERR;
                  err_d      = 1'b1;
                  err_code_d = ERR_TMO_EVT;
                  err_idx_d  = idx_q;
               end
            end
            S_SEND: begin
               send_cmd = 1'b1;
               state_d  = S_WAIT_SENT;
            end
            S_WAIT_SENT: begin
               if (cmd_sent) begin
                  timer_d = tmo_q;
                  state_d = S_WAIT_RESP;
               end
            end
            S_WAIT_RESP: begin
               // A response landing on the expiry cycle still wins.
               if (resp_rdy) begin
                  fifo_pop = 1'b1;
                  if (resp == ACK) begin
                     idx_d   = idx_q + IW'(1);
                     state_d = S_LOAD;
                  end else begin
                     state_d    = S_ERR;
                     err_d      = 1'b1;
                     err_code_d = ERR_NAK;
                     err_idx_d  = idx_q;
                     err_resp_d = resp;
                  end
               end else if (timer_expired) begin
                  state_d    = S_ERR;
                  err_d      = 1'b1;
                  err_code_d = ERR_TMO_RESP;
                  err_idx_d  = idx_q;
               end
            end
            S_DONE: begin
               done    = 1'b1;
               state_d = S_IDLE;
            end
            S_ERR: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cmd_q      <= '0;
         evt_sel_q  <= '0;
         tmo_q      <= '0;
         timer_q    <= '0;
         idx_q      <= '0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
         err_idx_q  <= '0;
         err_resp_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         evt_sel_q  <= evt_sel_d;
         tmo_q      <= tmo_d;
         timer_q    <= timer_d;
         idx_q      <= idx_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         err_idx_q  <= err_idx_d;
         err_resp_q <= err_resp_d;
         overflow_q <= overflow_d;
      end
   end

   assign cmd      = cmd_q;
   assign busy     = (state_q != S_IDLE);
   assign err      = err_q;
   assign err_code = err_code_q;
   assign err_idx  = err_idx_q;
   assign err_resp = err_resp_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_kt_cmd_sequencer.sv
// Directed bench for kt_cmd_sequencer with hand-computed expectations.
module tb_kt_cmd_sequencer;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [15:0] wr_cmd;
   logic [2:0]  wr_evt;
   logic [23:0] wr_tmo;
   logic        start;
   logic        abort;
   logic [3:0]  evt;
   logic [15:0] cmd;
   logic        send_cmd;
   logic        cmd_sent;
   logic        resp_rdy;
   logic [7:0]  resp;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [2:0]  err_idx;
   logic [7:0]  err_resp;
   logic [3:0]  count;
   logic        overflow;

   int n_assert = 0;
   int n_fail   = 0;
   int n_send   = 0;
   int snap;

   kt_cmd_sequencer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_cmd   (wr_cmd),
      .wr_evt   (wr_evt),
      .wr_tmo   (wr_tmo),
      .start    (start),
      .abort    (abort),
      .evt      (evt),
      .cmd      (cmd),
      .send_cmd (send_cmd),
      .cmd_sent (cmd_sent),
      .resp_rdy (resp_rdy),
      .resp     (resp),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .err_code (err_code),
      .err_idx  (err_idx),
      .err_resp (err_resp),
      .count    (count),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && send_cmd) n_send <= n_send + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] c, input logic [2:0] e, input logic [23:0] t);
      wr_en  = 1'b1;
      wr_cmd = c;
      wr_evt = e;
      wr_tmo = t;
      tick();
      wr_en  = 1'b0;
   endtask

   // Waits (bounded) for the send strobe, then completes the transmit and response.
   task automatic serve(input logic [7:0] r, input logic [15:0] exp_cmd, input string tag);
      int w = 0;
      while (send_cmd !== 1'b1 && w < 200) begin
         tick();
         w++;
      end
      check({tag, " send seen"}, 32'(send_cmd), 32'd1);
      check({tag, " cmd"}, 32'(cmd), 32'(exp_cmd));
      tick();
      cmd_sent = 1'b1;
      tick();
      cmd_sent = 1'b0;
      resp     = r;
      resp_rdy = 1'b1;
      tick();
      resp_rdy = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_cmd = '0; wr_evt = '0; wr_tmo = '0;
      start = 1'b0; abort = 1'b0; evt = '0; cmd_sent = 1'b0; resp_rdy = 1'b0; resp = '0;
      repeat (3) tick();
      check("rst busy", 32'(busy), 0);
      check("rst send", 32'(send_cmd), 0);
      check("rst done", 32'(done), 0);
      check("rst err", 32'(err), 0);
      check("rst count", 32'(count), 0);
      check("rst cmd", 32'(cmd), 0);
      rst_n = 1'b1;
      tick();

      // Test 1: event-gated entry, event rises ~50 cycles after start
      push(16'h2000, 3'd1, 24'd1000);
      check("t1 count", 32'(count), 1);
      snap  = n_send;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      repeat (47) tick();
      check("t1 no early send", 32'(n_send - snap), 0);
      evt[0] = 1'b1;
      tick();
      check("t1 send after evt", 32'(send_cmd), 1);
      serve(8'hA5, 16'h2000, "t1");
      evt[0] = 1'b0;
      check("t1 count after pop", 32'(count), 0);
      tick();
      check("t1 done", 32'(done), 1);
      check("t1 err", 32'(err), 0);
      check("t1 one send", 32'(n_send - snap), 1);
      tick();
      check("t1 done cleared", 32'(done), 0);
      check("t1 idle", 32'(busy), 0);

      // Test 2: event never rises, timeout 100
      push(16'h2000, 3'd1, 24'd100);
      snap  = n_send;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      repeat (100) tick();
      check("t2 no err before expiry", 32'(err), 0);
      tick();
      check("t2 err", 32'(err), 1);
      check("t2 err_code", 32'(err_code), 1);
      check("t2 err_idx", 32'(err_idx), 0);
      check("t2 count kept", 32'(count), 1);
      check("t2 no send", 32'(n_send - snap), 0);
      tick();
      check("t2 idle", 32'(busy), 0);
      check("t2 err sticky", 32'(err), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t2 flush count", 32'(count), 0);
      check("t2 abort keeps err", 32'(err), 1);

      // Test 3: second response is a NAK
      push(16'h3001, 3'd0, 24'd0);
      push(16'h3002, 3'd0, 24'd0);
      push(16'h3003, 3'd0, 24'd0);
      check("t3 count", 32'(count), 3);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t3 start clears err", 32'(err), 0);
      check("t3 start clears code", 32'(err_code), 0);
      tick();
      check("t3 latency 2", 32'(send_cmd), 1);
      serve(8'hA5, 16'h3001, "t3a");
      check("t3 after ack count", 32'(count), 2);
      serve(8'h5A, 16'h3002, "t3b");
      check("t3 err", 32'(err), 1);
      check("t3 err_code", 32'(err_code), 3);
      check("t3 err_idx", 32'(err_idx), 1);
      check("t3 err_resp", 32'(err_resp), 32'h5A);
      check("t3 count", 32'(count), 1);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t3 flush", 32'(count), 0);

      // Test 4: overflow with nine pushes, then drain eight entries
      for (int i = 0; i < 8; i++) push(16'(16'h4000 + i), 3'd0, 24'd0);
      check("t4 full count", 32'(count), 8);
      check("t4 no overflow yet", 32'(overflow), 0);
      push(16'h4008, 3'd0, 24'd0);
      check("t4 count capped", 32'(count), 8);
      check("t4 overflow", 32'(overflow), 1);
      snap  = n_send;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) serve(8'hA5, 16'(16'h4000 + i), "t4");
      tick();
      check("t4 done", 32'(done), 1);
      check("t4 eight sends", 32'(n_send - snap), 8);
      check("t4 drained", 32'(count), 0);
      tick();

      // Test 5: abort in WAIT_RESP with three queued, and abort during SEND
      push(16'h5001, 3'd0, 24'd0);
      push(16'h5002, 3'd0, 24'd0);
      push(16'h5003, 3'd0, 24'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      cmd_sent = 1'b1;
      tick();
      cmd_sent = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t5 busy", 32'(busy), 0);
      check("t5 count", 32'(count), 0);
      check("t5 err", 32'(err), 0);
      resp     = 8'hA5;
      resp_rdy = 1'b1;
      tick();
      resp_rdy = 1'b0;
      check("t5 late resp busy", 32'(busy), 0);
      check("t5 late resp done", 32'(done), 0);
      push(16'h5004, 3'd0, 24'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      abort = 1'b1;
      #1;
      check("t5 send forced low", 32'(send_cmd), 0);
      tick();
      abort = 1'b0;
      check("t5b idle", 32'(busy), 0);
      check("t5b count", 32'(count), 0);

      // Test 6: empty queue, then response on the expiry cycle, then a response timeout
      snap  = n_send;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t6 not done yet", 32'(done), 0);
      tick();
      check("t6 done", 32'(done), 1);
      check("t6 no send", 32'(n_send - snap), 0);
      tick();
      check("t6 idle", 32'(busy), 0);

      push(16'h6001, 3'd0, 24'd5);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      cmd_sent = 1'b1;
      tick();
      cmd_sent = 1'b0;
      repeat (5) tick();
      check("t6 no err at timer 0", 32'(err), 0);
      check("t6 still busy", 32'(busy), 1);
      resp     = 8'hA5;
      resp_rdy = 1'b1;
      tick();
      resp_rdy = 1'b0;
      check("t6 resp wins err", 32'(err), 0);
      check("t6 popped", 32'(count), 0);
      tick();
      check("t6 done after resp", 32'(done), 1);

      push(16'h6002, 3'd0, 24'd3);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      cmd_sent = 1'b1;
      tick();
      cmd_sent = 1'b0;
      repeat (3) tick();
      check("t6 resp tmo not yet", 32'(err), 0);
      tick();
      check("t6 resp tmo err", 32'(err), 1);
      check("t6 resp tmo code", 32'(err_code), 2);
      check("t6 resp tmo idx", 32'(err_idx), 0);
      check("t6 resp tmo count", 32'(count), 1);
      tick();

      // Mid-operation asynchronous reset
      push(16'h7001, 3'd0, 24'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("mr send before", 32'(send_cmd), 1);
      rst_n = 1'b0;
      #1;
      check("mr send", 32'(send_cmd), 0);
      check("mr busy", 32'(busy), 0);
      check("mr cmd", 32'(cmd), 0);
      check("mr count", 32'(count), 0);
      check("mr overflow", 32'(overflow), 0);
      check("mr err", 32'(err), 0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
